// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores to external data memory via req/ack,
// handles byte/word access, alignment errors and abandoned (timed-out) accesses.
`timescale 1ns/1ps
module mem_access_stage #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inValid,
  input  logic [15:0] aluResult,
  input  logic [15:0] storeData,
  input  logic [15:0] R0in,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        byteOp,
  input  logic        signExt,
  output logic        stall,
  output logic        memReq,
  output logic        memWe,
  output logic [14:0] memAddr,
  output logic [1:0]  memBe,
  output logic [15:0] memWdata,
  input  logic [15:0] memRdata,
  input  logic        memAck,
  output logic [15:0] result,
  output logic [15:0] dataOut,
  output logic [15:0] R0out,
  output logic        outValid,
  output logic        errAlign,
  output logic        errTimeout
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [15:0]      addr_reg;
  logic [15:0]      r0_reg;
  logic             store_reg;
  logic             byte_reg;
  logic             sext_reg;

  logic        is_mem;
  logic        misaligned;
  logic        timed_out;
  logic [7:0]  load_byte;
  logic [15:0] load_data;

  assign is_mem     = memRead | memWrite;
  assign misaligned = is_mem && !byteOp && aluResult[0];
  assign timed_out  = (cnt_reg == TIMEOUT_CNT);

  // Byte loads pick the lane named by the latched address LSB.
  assign load_byte = addr_reg[0] ? memRdata[15:8] : memRdata[7:0];
  assign load_data = byte_reg ? {{8{sext_reg & load_byte[7]}}, load_byte} : memRdata;

  always_comb begin
    stall = 1'b0;
    if (state_reg == IDLE)
      stall = inValid && is_mem && !misaligned;
    else
      stall = !memAck && !timed_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      addr_reg   <= '0;
      r0_reg     <= '0;
      store_reg  <= 1'b0;
      byte_reg   <= 1'b0;
      sext_reg   <= 1'b0;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memBe      <= '0;
      memWdata   <= '0;
      result     <= '0;
      dataOut    <= '0;
      R0out      <= '0;
      outValid   <= 1'b0;
      errAlign   <= 1'b0;
      errTimeout <= 1'b0;
    end else begin
      outValid   <= 1'b0;
      errAlign   <= 1'b0;
      errTimeout <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (inValid) begin
            if (is_mem && !misaligned) begin
              state_reg <= REQ;
              cnt_reg   <= '0;
              addr_reg  <= aluResult;
              r0_reg    <= R0in;
              store_reg <= memWrite;
              byte_reg  <= byteOp;
              sext_reg  <= signExt;
              memReq    <= 1'b1;
              memWe     <= memWrite;
              memAddr   <= aluResult[15:1];
              memBe     <= byteOp ? (aluResult[0] ? 2'b10 : 2'b01) : 2'b11;
              memWdata  <= byteOp ? {2{storeData[7:0]}} : storeData;
            end else begin
              result   <= aluResult;
              dataOut  <= '0;
              R0out    <= R0in;
              outValid <= 1'b1;
              errAlign <= misaligned;
            end
          end
        end
        REQ: begin
          // An ack in the timeout cycle still completes the access normally.
          if (memAck) begin
            state_reg <= IDLE;
            memReq    <= 1'b0;
            outValid  <= 1'b1;
            result    <= addr_reg;
            R0out     <= r0_reg;
            dataOut   <= store_reg ? 16'h0000 : load_data;
          end else if (timed_out) begin
            state_reg  <= IDLE;
            memReq     <= 1'b0;
            outValid   <= 1'b1;
            errTimeout <= 1'b1;
            result     <= addr_reg;
            R0out      <= r0_reg;
            dataOut    <= 16'hFFFF;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 16-bit pipeline. Sits between the EX/MEM pipeline register and the MEM/WB buffer.
- Performs loads and stores against an external data memory through a req/ack handshake. Memory latency is variable.
- Supports word and byte access with optional sign extension. Stalls upstream while an access is outstanding.
- Presents result, loaded data and R0 to MEM/WB with a one-cycle valid pulse per instruction.

Parameters:
TIMEOUT, 15, max cycles in REQ without memAck before the access is abandoned
CNT_W, 4, width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT)

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  synchronous, active-high
inValid  input  1  EX/MEM holds a valid instruction
aluResult  input  16  ALU result or effective byte address
storeData  input  16  store source data
R0in  input  16  R0 value travelling with the instruction
memRead  input  1  load
memWrite  input  1  store (wins if memRead also high)
byteOp  input  1  byte access when 1, word when 0
signExt  input  1  sign-extend byte loads when 1, zero-extend when 0
stall  output  1  upstream must hold its inputs (combinational)
memReq  output  1  registered request, held until ack or timeout
memWe  output  1  write enable, registered with memReq
memAddr  output  15  word address = addr[15:1]
memBe  output  2  byte enables, [0] = low/even byte
memWdata  output  16  write data
memRdata  input  16  read data, valid when memAck=1
memAck  input  1  access complete this cycle
result  output  16  registered aluResult to MEM/WB
dataOut  output  16  registered load data to MEM/WB
R0out  output  16  registered R0 to MEM/WB
outValid  output  1  one-cycle pulse: result/dataOut/R0out updated
errAlign  output  1  one-cycle pulse: misaligned word access
errTimeout  output  1  one-cycle pulse: access abandoned

Behaviour:
- States are IDLE and REQ. Reset forces IDLE.
- Reset zeroes every registered output: memReq, memWe, memAddr, memBe, memWdata, result, dataOut, R0out, outValid, errAlign, errTimeout. Timeout counter is also zeroed.
- Reset mid-access drops memReq the next cycle. No output pulse is produced for the aborted access.
- IDLE, inValid=0:
  - outValid, errAlign and errTimeout are 0.
  - result, dataOut and R0out hold their values.
- IDLE, inValid=1, no memory op:
  - At the next edge: result=aluResult, dataOut=0, R0out=R0in, outValid=1.
  - stall=0. Latency is 1.
- IDLE, inValid=1, word op with aluResult[0]=1 (misaligned):
  - No request is issued.
  - At the next edge: result=aluResult, dataOut=0, R0out=R0in, outValid=1, errAlign=1.
  - stall=0.
- IDLE, inValid=1, aligned memory op:
  - stall=1 combinationally in that cycle.
  - At the next edge: latch the op, go to REQ, memReq=1, memWe=memWrite, memAddr=aluResult[15:1], counter=0.
  - Word access: memBe=11, memWdata=storeData.
  - Byte access: memBe = aluResult[0] ? 10 : 01, memWdata={storeData[7:0],storeData[7:0]}.
- REQ:
  - stall = !memAck && (counter != TIMEOUT).
  - memReq and the request fields stay constant.
  - counter increments each cycle without ack.
- REQ, memAck=1:
  - At the edge: memReq=0, go to IDLE, outValid=1, result=latched address, R0out=latched R0.
  - Store: dataOut=0.
  - Word load: dataOut=memRdata.
  - Byte load: select memRdata[15:8] if addr[0], else memRdata[7:0]. Extend to 16 bits per signExt.
  - Minimum latency is issue cycle N to outValid at N+2.
  - The upstream stage advances in the ack cycle because stall=0. The next instruction is evaluated in IDLE at the following cycle.
- REQ, counter==TIMEOUT without ack:
  - At the edge: memReq=0, go to IDLE, outValid=1, errTimeout=1, dataOut=16'hFFFF, result and R0out as for completion.
- memAck while not in REQ is ignored.
- memAck and timeout in the same cycle: ack wins, no errTimeout.
- memRead and memWrite both high: treated as a store.

Test Plan:
- Non-memory op aluResult=16'h1234, R0in=16'h00AA -> next cycle result=16'h1234, dataOut=0, R0out=16'h00AA, outValid=1, stall=0 throughout.
- Word load addr=16'h0040, memAck 3 cycles after memReq, memRdata=16'hBEEF -> memAddr=15'h0020, memBe=11, stall high 3 cycles, dataOut=16'hBEEF, outValid pulse one cycle after ack.
- Byte load addr=16'h0041, memRdata=16'h8001: with signExt=1 -> dataOut=16'hFF80; repeat with signExt=0 -> dataOut=16'h0080; memBe=10 in both.
- Byte store addr=16'h0010, storeData=16'h12AB -> memWe=1, memBe=01, memWdata=16'hABAB; outValid after ack with dataOut=0.
- Word load addr=16'h0003 -> no memReq, errAlign=1 and outValid=1 next cycle, dataOut=0; separately, no ack for TIMEOUT=15 cycles -> memReq drops, errTimeout=1, dataOut=16'hFFFF.
- reset asserted in the 2nd REQ cycle -> next cycle memReq=0, state IDLE, all outputs 0, no outValid; a later ack is ignored.
